enc_onehot_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among up to 15 requesters.
- Grant is issued both as a registered one-hot vector and as its binary index, so the grant vector can drive one-hot select fabric directly.
- The binary index feeds the enc_bin2onehot decode path elsewhere in the block.
- Enforces a maximum hold time and a one-cycle turnaround gap between grants.

---
 rtl/enc_onehot_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_enc_onehot_rr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_onehot_rr_arbiter.sv
// Round-robin arbiter for up to 15 requesters. The grant is registered as a
// one-hot vector with a matching binary index. Each grant is capped at
// MAX_HOLD cycles and is always followed by a one-cycle turnaround gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; arbitrates when en_i=1 and any request is set
// ST_GRANT | one requester owns the resource; hold counter running
// ST_GAP   | one-cycle turnaround after a release; requests ignored

module enc_onehot_rr_arbiter #(
   parameter int N        = 15,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o,
   output logic             timeout_o
);

   localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [IDX_W-1:0]  ptr_q,     ptr_d;
   logic [HOLD_W-1:0] hold_q,    hold_d;
   logic [N-1:0]      gnt_q,     gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
   logic              timeout_q, timeout_d;

   // Arbitration helpers
   logic [N-1:0]      req_hi;
   logic              hi_any;
   logic [IDX_W-1:0]  hi_idx;
   logic              lo_any;
   logic [IDX_W-1:0]  lo_idx;
   logic              sel_any;
   logic [IDX_W-1:0]  sel_idx;
   logic [N-1:0]      sel_onehot;

   // Release-path helpers
   logic              owner_req;
   logic              hold_expired;
   logic [IDX_W-1:0]  ptr_after_release;

   // Rotating-priority pick: requests at or above ptr win first; if none,
   // wrap to the lowest set request below ptr.
   always_comb begin
      req_hi = '0;
      for (int i = 0; i < N; i++) begin
         req_hi[i] = req_i[i] & (IDX_W'(i) >= ptr_q);
      end
   end

   // Lowest set bit of the masked (at/above ptr) request vector.
   always_comb begin
      hi_any = 1'b0;
      hi_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_hi[i]) begin
            hi_any = 1'b1;
            hi_idx = IDX_W'(i);
         end
      end
   end

   // Lowest set bit of the raw request vector, used when the search wraps.
   always_comb begin
      lo_any = 1'b0;
      lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            lo_any = 1'b1;
            lo_idx = IDX_W'(i);
         end
      end
   end

   // Final selection and its one-hot form.
   always_comb begin
      sel_any    = hi_any | lo_any;
      sel_idx    = hi_any ? hi_idx : lo_idx;
      sel_onehot = '0;
      for (int i = 0; i < N; i++) begin
         sel_onehot[i] = sel_any && (IDX_W'(i) == sel_idx);
      end
   end

   // The owner's request is read through the one-hot grant, which avoids an
   // out-of-range index when IDX_W can address more than N bits.
   always_comb begin
      owner_req         = |(req_i & gnt_q);
      hold_expired      = (hold_q == HOLD_LIMIT);
      ptr_after_release = (gnt_idx_q == LAST_IDX) ? '0 : (gnt_idx_q + IDX_ONE);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      timeout_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            gnt_d     = '0;
            gnt_idx_d = '0;
            hold_d    = '0;
            if (en_i && sel_any) begin
               state_d   = ST_GRANT;
               gnt_d     = sel_onehot;
               gnt_idx_d = sel_idx;
               hold_d    = HOLD_ONE;
            end
         end

         ST_GRANT: begin
            if (!owner_req || hold_expired) begin
               // A request drop takes precedence over expiry, so a
               // simultaneous drop and expiry is a plain release.
               state_d   = ST_GAP;
               gnt_d     = '0;
               gnt_idx_d = '0;
               hold_d    = '0;
               ptr_d     = ptr_after_release;
               timeout_d = owner_req;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end

         ST_GAP: begin
            state_d   = ST_IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            hold_d    = '0;
         end

         default: begin
            state_d   = ST_IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            hold_d    = '0;
         end
      endcase
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_valid_o = |gnt_q;
   assign timeout_o   = timeout_q;

   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(gnt_q));

   a_hold_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      hold_q <= HOLD_LIMIT);

endmodule

// File: tb/tb_enc_onehot_rr_arbiter.sv
// Testbench for enc_onehot_rr_arbiter: directed scenarios plus a randomized
// run, all compared against a cycle-level ownership model of the arbiter.

module tb_enc_onehot_rr_arbiter;

   localparam int N        = 15;
   localparam int IDX_W    = 4;
   localparam int MAX_HOLD = 8;
   localparam int VW       = N + IDX_W + 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the resource, for how long, where the next
   // search starts and how many quiet cycles remain before arbitration.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int m_cool  = 0;
   bit m_to    = 1'b0;

   enc_onehot_rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .req_i       (req),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid),
      .timeout_o   (timeout)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      m_to = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_held  = 0;
         m_ptr   = 0;
         m_cool  = 0;
      end else if (m_owner >= 0) begin
         if (!req[m_owner] || m_held == MAX_HOLD) begin
            m_to    = req[m_owner];
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
            m_cool  = 1;
         end else begin
            m_held++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (en && req != '0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && req[c]) begin
               m_owner = c;
               m_held  = 1;
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] m_vec();
      logic [N-1:0]     g;
      logic [IDX_W-1:0] ix;
      logic             v;
      g  = '0;
      ix = '0;
      v  = 1'b0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         ix         = IDX_W'(m_owner);
         v          = 1'b1;
      end
      return {g, ix, v, m_to};
   endfunction

   // Advance one clock, update the model with the sampled inputs, then
   // settle past the edge before anything looks at the outputs.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      req = 15'h7FFF;
      tick();
      tick();
      checks++;
      if ({gnt, gnt_valid, timeout} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got gnt=%h valid=%b to=%b, want all zero", gnt, gnt_valid, timeout);
      end
      checks++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
         failures++;
         $display("FAIL reset_model: got %h, want %h", {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
      end
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 15'h0001 || gnt_idx !== 4'd0 || gnt_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant: got gnt=%h idx=%0d valid=%b, want 0001/0/1", gnt, gnt_idx, gnt_valid);
      end
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
            failures++;
            $display("FAIL reset_drain: got %h, want %h", {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
         end
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int run;
      int zeros;
      int cyc;
      rst = 1'b1;
      req = 15'h7FFF;
      en  = 1'b1;
      tick();
      rst   = 1'b0;
      run   = 0;
      zeros = 0;
      cyc   = 0;
      while (order.size() < N + 1 && cyc < 200) begin
         tick();
         cyc++;
         checks++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
            failures++;
            $display("FAIL rr_model: cycle %0d got %h, want %h", cyc, {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
         end
         if (gnt_valid) begin
            if (run == 0) begin
               if (order.size() > 0) begin
                  checks++;
                  if (zeros != 2) begin
                     failures++;
                     $display("FAIL rr_gap: got %0d idle cycles before grant %0d, want 2", zeros, order.size());
                  end
               end
               order.push_back(int'(gnt_idx));
               zeros = 0;
            end
            run++;
            if (run == 2) req[gnt_idx] = 1'b0;
         end else begin
            run = 0;
            zeros++;
            req = 15'h7FFF;
         end
      end
      checks++;
      if (order.size() != N + 1) begin
         failures++;
         $display("FAIL rr_timeout: got %0d grants in budget, want %0d", order.size(), N + 1);
      end
      foreach (order[k]) begin
         checks++;
         if (order[k] != k % N) begin
            failures++;
            $display("FAIL rr_order: grant %0d got index %0d, want %0d", k, order[k], k % N);
         end
      end
      req = '0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_timeout();
      int cnt;
      int waited;
      req    = 15'h0020;
      waited = 0;
      while (!gnt_valid && waited < 10) begin
         tick();
         waited++;
      end
      checks++;
      if (gnt !== 15'h0020) begin
         failures++;
         $display("FAIL to_first_grant: got gnt=%h after %0d cycles, want 0020", gnt, waited);
      end
      cnt = 0;
      while (gnt === 15'h0020 && cnt < 20) begin
         cnt++;
         tick();
         checks++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
            failures++;
            $display("FAIL to_model: got %h, want %h", {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
         end
      end
      checks++;
      if (cnt != MAX_HOLD) begin
         failures++;
         $display("FAIL to_hold_len: got %0d grant cycles, want %0d", cnt, MAX_HOLD);
      end
      checks++;
      if (gnt !== '0 || timeout !== 1'b1) begin
         failures++;
         $display("FAIL to_pulse: got gnt=%h to=%b, want 0000/1", gnt, timeout);
      end
      tick();
      checks++;
      if (gnt !== '0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL to_pulse_end: got gnt=%h to=%b, want 0000/0", gnt, timeout);
      end
      tick();
      checks++;
      if (gnt !== 15'h0020 || gnt_idx !== 4'd5) begin
         failures++;
         $display("FAIL to_regrant: got gnt=%h idx=%0d, want 0020/5", gnt, gnt_idx);
      end
      req = '0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_drop_at_expiry();
      int waited;
      req    = 15'h0008;
      waited = 0;
      while (!gnt_valid && waited < 10) begin
         tick();
         waited++;
      end
      checks++;
      if (gnt !== 15'h0008) begin
         failures++;
         $display("FAIL dx_grant: got gnt=%h, want 0008", gnt);
      end
      for (int i = 0; i < MAX_HOLD - 1; i++) tick();
      checks++;
      if (gnt !== 15'h0008) begin
         failures++;
         $display("FAIL dx_last_cycle: got gnt=%h on cycle %0d, want 0008", gnt, MAX_HOLD);
      end
      req = '0;
      tick();
      checks++;
      if (gnt !== '0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL dx_release: got gnt=%h to=%b, want 0000/0", gnt, timeout);
      end
      checks++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
         failures++;
         $display("FAIL dx_model: got %h, want %h", {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_enable();
      en  = 1'b0;
      req = 15'h0010;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (gnt !== '0) begin
            failures++;
            $display("FAIL en_low_no_grant: got gnt=%h, want 0000", gnt);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (gnt !== 15'h0010) begin
         failures++;
         $display("FAIL en_rise_grant: got gnt=%h, want 0010", gnt);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt !== 15'h0010) begin
            failures++;
            $display("FAIL en_fall_hold: got gnt=%h, want 0010", gnt);
         end
      end
      req = '0;
      tick();
      checks++;
      if (gnt !== '0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL en_release: got gnt=%h to=%b, want 0000/0", gnt, timeout);
      end
      en = 1'b1;
      for (int i = 0; i < 2; i++) tick();
   endtask

   task automatic test_reset_mid_grant();
      int waited;
      req    = 15'h0400;
      waited = 0;
      while (!gnt_valid && waited < 10) begin
         tick();
         waited++;
      end
      tick();
      checks++;
      if (gnt !== 15'h0400) begin
         failures++;
         $display("FAIL rmg_grant: got gnt=%h, want 0400", gnt);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (gnt !== '0 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmg_drop: got gnt=%h to=%b valid=%b, want 0000/0/0", gnt, timeout, gnt_valid);
      end
      rst = 1'b0;
      req = 15'h0401;
      tick();
      checks++;
      if (gnt !== 15'h0001 || gnt_idx !== 4'd0) begin
         failures++;
         $display("FAIL rmg_ptr_reset: got gnt=%h idx=%0d, want 0001/0", gnt, gnt_idx);
      end
      req = '0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         en  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) req = N'($urandom);
            else req = N'(1) << $urandom_range(0, N - 1);
         end
         tick();
         checks++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== m_vec()) begin
            failures++;
            $display("FAIL rand_model: cycle %0d got %h, want %h", i, {gnt, gnt_idx, gnt_valid, timeout}, m_vec());
         end
      end
      rst = 1'b0;
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      req = '0;
      test_reset();
      test_round_robin();
      test_timeout();
      test_drop_at_expiry();
      test_enable();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
